// File: rtl/acc_ctrl_pkg.sv
// Shared widths, plane limit and FSM state encoding for the bit-plane
// accumulator sequencer.
package acc_ctrl_pkg;

    localparam int PS_W       = 27;
    localparam int ACC_W      = 51;
    localparam int MAX_PLANES = 24;
    localparam int IDX_W      = $clog2(MAX_PLANES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_CAPTURE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/plane_buf.sv
// Bit-plane partial-sum store: one synchronous write port, one combinational
// read port. Contents are intentionally left unreset.
module plane_buf #(
    parameter int DEPTH = acc_ctrl_pkg::MAX_PLANES,
    parameter int W     = acc_ctrl_pkg::PS_W,
    parameter int AW    = acc_ctrl_pkg::IDX_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequencer that buffers N partial sums, then streams them MSB plane first
// into an external shift-accumulator without gaps and captures the result.
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | accepting partial sums into the buffer
//   STREAM  | feeding buffered planes to the accumulator, one per cycle
//   CAPTURE | accumulator cleared, result registered
//   DONE    | result held until res_ready
module acc_seq_ctrl #(
    parameter int PS_W       = acc_ctrl_pkg::PS_W,
    parameter int ACC_W      = acc_ctrl_pkg::ACC_W,
    parameter int MAX_PLANES = acc_ctrl_pkg::MAX_PLANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       cfg_planes,
    input  logic             abort,
    input  logic             ps_valid,
    output logic             ps_ready,
    input  logic [PS_W-1:0]  ps_data,
    output logic             acc_st,
    output logic [PS_W-1:0]  acc_din,
    input  logic [ACC_W-1:0] acc_nout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    import acc_ctrl_pkg::*;

    localparam int IW = $clog2(MAX_PLANES + 1);

    state_t          state, state_n;
    logic [IW-1:0]   nc, nc_n, nc_req;
    logic [IW-1:0]   wr_idx, wr_idx_n;
    logic [IW-1:0]   rd_idx, rd_idx_n;
    logic            wr_en;
    logic [PS_W-1:0] rd_data;

    plane_buf #(
        .DEPTH (MAX_PLANES),
        .W     (PS_W),
        .AW    (IW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_idx),
        .wdata (ps_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            nc       <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            res_data <= '0;
        end else begin
            state  <= state_n;
            nc     <= nc_n;
            wr_idx <= wr_idx_n;
            rd_idx <= rd_idx_n;
            if (state == ST_CAPTURE) res_data <= acc_nout;
        end
    end

    always_comb begin
        state_n  = state;
        nc_n     = nc;
        wr_idx_n = wr_idx;
        rd_idx_n = rd_idx;
        wr_en    = 1'b0;
        if (32'(cfg_planes) > 32'(MAX_PLANES)) nc_req = IW'(MAX_PLANES);
        else                                   nc_req = IW'(cfg_planes);

        case (state)
            ST_IDLE: begin
                wr_idx_n = '0;
                rd_idx_n = '0;
                if (start) begin
                    nc_n    = nc_req;
                    state_n = (nc_req == '0) ? ST_CAPTURE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ps_valid) begin
                    wr_en    = 1'b1;
                    wr_idx_n = wr_idx + IW'(1);
                    if (wr_idx == nc - IW'(1)) begin
                        state_n  = ST_STREAM;
                        rd_idx_n = '0;
                    end
                end
            end
            ST_STREAM: begin
                rd_idx_n = rd_idx + IW'(1);
                if (rd_idx == nc - IW'(1)) state_n = ST_CAPTURE;
            end
            ST_CAPTURE: state_n = ST_DONE;
            ST_DONE:    if (res_ready) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase

        // abort overrides every transition, including a DONE handshake
        if (abort && state != ST_IDLE) begin
            state_n  = ST_IDLE;
            wr_idx_n = '0;
            rd_idx_n = '0;
            wr_en    = 1'b0;
        end
    end

    assign ps_ready  = (state == ST_LOAD);
    assign acc_st    = (state != ST_STREAM);
    assign acc_din   = (state == ST_STREAM) ? rd_data : '0;
    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl with a behavioural shift-accumulator
// closing the loop on acc_st/acc_din/acc_nout.
module tb_acc_seq_ctrl;

    localparam int PS_W  = 27;
    localparam int ACC_W = 51;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [4:0]       cfg_planes;
    logic             abort;
    logic             ps_valid;
    logic             ps_ready;
    logic [PS_W-1:0]  ps_data;
    logic             acc_st;
    logic [PS_W-1:0]  acc_din;
    logic [ACC_W-1:0] acc_nout;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int s_cnt = 0;
    int s_runs = 0;
    int rv_cnt = 0;
    logic prev_st = 1'b1;
    logic [PS_W-1:0] pv [24];

    acc_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_planes (cfg_planes),
        .abort      (abort),
        .ps_valid   (ps_valid),
        .ps_ready   (ps_ready),
        .ps_data    (ps_data),
        .acc_st     (acc_st),
        .acc_din    (acc_din),
        .acc_nout   (acc_nout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // external accumulator: clear when acc_st, else shift-left and add
    always @(posedge clk or posedge rst) begin
        if (rst)         acc_nout <= '0;
        else if (acc_st) acc_nout <= '0;
        else             acc_nout <= (acc_nout << 1) + {{(ACC_W-PS_W){acc_din[PS_W-1]}}, acc_din};
    end

    always @(negedge clk) begin
        if (!acc_st) begin
            s_cnt = s_cnt + 1;
            if (prev_st) s_runs = s_runs + 1;
        end
        prev_st = acc_st;
        if (res_valid) rv_cnt = rv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int n, input int cfg, input int gap);
        int c0, r0, lat, tries;
        logic rdy;
        c0 = s_cnt;
        r0 = s_runs;
        cfg_planes = cfg[4:0];
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                ps_valid = 1'b0;
                ps_data  = 27'h5A5A5A5;
                step();
            end
            ps_valid = 1'b1;
            ps_data  = pv[i];
            tries = 0;
            do begin
                rdy = ps_ready;
                step();
                tries++;
            end while (!rdy && tries < 50);
            if (!rdy) chk("beat_accept", 64'(rdy), 64'd1);
        end
        ps_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 200) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'(n + 1));
        chk("stream_cycles", 64'(s_cnt - c0), 64'(n));
        chk("stream_runs", 64'(s_runs - r0), (n == 0) ? 64'd0 : 64'd1);
    endtask

    task automatic finish_job();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("idle_after_handshake", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        rst = 1'b1;
        start = 1'b0;
        cfg_planes = '0;
        abort = 1'b0;
        ps_valid = 1'b0;
        ps_data = '0;
        res_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ps_ready", 64'(ps_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_acc_st", 64'(acc_st), 64'd1);
        chk("rst_acc_din", 64'(acc_din), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        rst = 1'b0;
        step();

        pv[0] = 27'd5;
        run_job(1, 1, 0);
        chk("n1_res", 64'(res_data), 64'd5);
        finish_job();

        pv[0] = 27'd1; pv[1] = 27'd2; pv[2] = 27'd3;
        run_job(3, 3, 2);
        chk("n3_gap_res", 64'(res_data), 64'd11);
        finish_job();

        pv[0] = 27'h7FFFFFF; pv[1] = 27'h7FFFFFF;
        run_job(2, 2, 0);
        chk("n2_neg_res", 64'(res_data), 64'h7FFFFFFFFFFFD);
        finish_job();

        for (int i = 0; i < 24; i++) pv[i] = 27'h3FFFFFF;
        run_job(24, 24, 0);
        chk("n24_max_res", 64'(res_data), ((64'd1 << 26) - 64'd1) * ((64'd1 << 24) - 64'd1));
        finish_job();

        run_job(0, 0, 0);
        chk("n0_res", 64'(res_data), 64'd0);
        finish_job();

        for (int i = 0; i < 24; i++) pv[i] = 27'd1;
        run_job(24, 31, 0);
        chk("clamp_res", 64'(res_data), 64'hFFFFFF);
        finish_job();

        // abort in the second STREAM cycle of a 5-plane job
        cfg_planes = 5'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps_valid = 1'b1;
            ps_data  = 27'(i + 1);
            step();
        end
        ps_valid = 1'b0;
        step();
        chk("abort_in_stream", 64'(acc_st), 64'd0);
        rv0 = rv_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_acc_st", 64'(acc_st), 64'd1);
        chk("abort_res_valid", 64'(res_valid), 64'd0);
        repeat (5) step();
        chk("abort_no_pulse", 64'(rv_cnt - rv0), 64'd0);
        pv[0] = 27'd7;
        run_job(1, 1, 0);
        chk("after_abort_res", 64'(res_data), 64'd7);
        finish_job();

        // DONE held with res_ready low and a stray start
        pv[0] = 27'd3; pv[1] = 27'd1;
        run_job(2, 2, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                cfg_planes = 5'd1;
            end
            step();
            start = 1'b0;
            chk("hold_res_data", 64'(res_data), 64'd7);
            chk("hold_res_valid", 64'(res_valid), 64'd1);
        end
        finish_job();
        chk("hold_ps_ready", 64'(ps_ready), 64'd0);

        pv[0] = 27'd9;
        run_job(1, 1, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done_valid", 64'(res_valid), 64'd0);
        chk("abort_done_busy", 64'(busy), 64'd0);

        // asynchronous reset in the middle of LOAD
        cfg_planes = 5'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        ps_valid = 1'b1;
        ps_data = 27'd2;
        repeat (2) step();
        ps_valid = 1'b0;
        rv0 = rv_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ps_ready", 64'(ps_ready), 64'd0);
        chk("midrst_res_data", 64'(res_data), 64'd0);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("midrst_no_pulse", 64'(rv_cnt - rv0), 64'd0);

        pv[0] = 27'h7FFFFFF;
        run_job(1, 1, 0);
        chk("n1_neg_res", 64'(res_data), 64'h7FFFFFFFFFFFF);
        finish_job();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
